systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 144 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic MAC array: clear, compute (feed + drain), row readout, done.
// Define SYSTOLIC_CTRL_CLEAR_EN to include the accumulator CLEAR phase; without it accumulators carry over.
module systolic_ctrl #(
   parameter int DIM = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   out_rdy,
   output logic                   en,
   output logic                   wr_en,
   output logic [$clog2(DIM)-1:0] crow,
   output logic                   cin_zero,
   output logic                   feed_vld,
   output logic [$clog2(DIM)-1:0] feed_idx,
   output logic                   out_vld,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = $clog2(DIM);
   localparam int PW = $clog2(3 * DIM);

   localparam logic [PW-1:0] ROW_LAST  = PW'(DIM - 1);
   localparam logic [PW-1:0] COMP_LAST = PW'(3 * DIM - 3);
   localparam logic [PW-1:0] FEED_END  = PW'(DIM);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
`ifdef SYSTOLIC_CTRL_CLEAR_EN
      CLEAR   = 3'd1,
`endif
      COMPUTE = 3'd2,
      READ    = 3'd3,
      DONE    = 3'd4
   } state_e;

`ifdef SYSTOLIC_CTRL_CLEAR_EN
   localparam state_e JOB_FIRST = CLEAR;
`else
   localparam state_e JOB_FIRST = COMPUTE;
`endif

   state_e          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic            en_q, wr_en_q, cin_zero_q, feed_vld_q, out_vld_q, busy_q, done_q;
   logic [CW-1:0]   crow_q, feed_idx_q;

   // The phase counter restarts on every state entry; in READ it doubles as the row index.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = JOB_FIRST;
               phase_d = '0;
            end
         end
`ifdef SYSTOLIC_CTRL_CLEAR_EN
         CLEAR: begin
            if (phase_q == ROW_LAST) begin
               state_d = COMPUTE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
`endif
         COMPUTE: begin
            if (phase_q == COMP_LAST) begin
               state_d = READ;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         READ: begin
            if (out_rdy) begin
               if (phase_q == ROW_LAST) begin
                  state_d = DONE;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            phase_d = '0;
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         en_q       <= 1'b0;
         wr_en_q    <= 1'b0;
         cin_zero_q <= 1'b0;
         feed_vld_q <= 1'b0;
         out_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         crow_q     <= '0;
         feed_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         en_q       <= (state_d == COMPUTE);
         feed_vld_q <= (state_d == COMPUTE) && (phase_d < FEED_END);
         feed_idx_q <= ((state_d == COMPUTE) && (phase_d < FEED_END)) ? phase_d[CW-1:0] : '0;
         out_vld_q  <= (state_d == READ);
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == DONE);
`ifdef SYSTOLIC_CTRL_CLEAR_EN
         wr_en_q    <= (state_d == CLEAR);
         cin_zero_q <= (state_d == CLEAR);
         crow_q     <= ((state_d == CLEAR) || (state_d == READ)) ? phase_d[CW-1:0] : '0;
`else
         wr_en_q    <= 1'b0;
         cin_zero_q <= 1'b0;
         crow_q     <= (state_d == READ) ? phase_d[CW-1:0] : '0;
`endif
      end
   end

   assign en       = en_q;
   assign wr_en    = wr_en_q;
   assign cin_zero = cin_zero_q;
   assign feed_vld = feed_vld_q;
   assign feed_idx = feed_idx_q;
   assign out_vld  = out_vld_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign crow     = crow_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (DIM=8): full jobs, READ stall, held start, mid-COMPUTE reset.
// Follows SYSTOLIC_CTRL_CLEAR_EN the same way the design does.
module tb_systolic_ctrl;

   localparam int DIM = 8;
   localparam int CW  = 3;
`ifdef SYSTOLIC_CTRL_CLEAR_EN
   localparam int CLR = DIM;
`else
   localparam int CLR = 0;
`endif

   localparam int K_IDLE = 0, K_CLEAR = 1, K_COMP = 2, K_READ = 3, K_DONE = 4;

   logic          clk = 1'b0;
   logic          rst, start, out_rdy;
   logic          en, wr_en, cin_zero, feed_vld, out_vld, busy, done;
   logic [CW-1:0] crow, feed_idx;

   int checks   = 0;
   int failures = 0;

   systolic_ctrl #(.DIM(DIM)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .out_rdy  (out_rdy),
      .en       (en),
      .wr_en    (wr_en),
      .crow     (crow),
      .cin_zero (cin_zero),
      .feed_vld (feed_vld),
      .feed_idx (feed_idx),
      .out_vld  (out_vld),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Expected {busy,en,wr_en,cin_zero,feed_vld,out_vld,done,crow,feed_idx} for a phase kind and index.
   function automatic logic [12:0] expVec(input int kind, input int k);
      logic       b, e, w, z, fv, ov, d;
      logic [2:0] cr, fi;
      b = 0; e = 0; w = 0; z = 0; fv = 0; ov = 0; d = 0; cr = '0; fi = '0;
      case (kind)
         K_CLEAR: begin b = 1; w = 1; z = 1; cr = 3'(k); end
         K_COMP: begin
            b = 1; e = 1;
            if (k < DIM) begin fv = 1; fi = 3'(k); end
         end
         K_READ: begin b = 1; ov = 1; cr = 3'(k); end
         K_DONE: begin b = 1; d = 1; end
         default: ;
      endcase
      return {b, e, w, z, fv, ov, d, cr, fi};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int kind, input int k);
      logic [12:0] observed, expected;
      observed = {busy, en, wr_en, cin_zero, feed_vld, out_vld, done, crow, feed_idx};
      expected = expVec(kind, k);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s k=%0d observed=%b expected=%b", tag, k, observed, expected);
      end
   endtask

   // Checks one job from its first active cycle through DONE, optionally stalling READ at one row.
   task automatic applyStimulus(input string tag, input int stallRow, input int stallN);
      for (int k = 0; k < CLR; k++) begin
         checkOutput({tag, "_clear"}, K_CLEAR, k);
         step();
      end
      for (int k = 0; k < 3 * DIM - 2; k++) begin
         checkOutput({tag, "_compute"}, K_COMP, k);
         step();
      end
      for (int r = 0; r < DIM; r++) begin
         if (r == stallRow) begin
            out_rdy = 1'b0;
            for (int s = 0; s < stallN; s++) begin
               checkOutput({tag, "_stall"}, K_READ, r);
               step();
            end
            out_rdy = 1'b1;
         end
         checkOutput({tag, "_read"}, K_READ, r);
         step();
      end
      checkOutput({tag, "_done"}, K_DONE, 0);
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_rdy = 1'b1;
      step();
      step();
      checkOutput("reset", K_IDLE, 0);
      rst = 1'b0;
      step();
      checkOutput("idle", K_IDLE, 0);

      // Single start pulse, consumer always ready.
      start = 1'b1;
      step();
      start = 1'b0;
      applyStimulus("job1", -1, 0);
      checkOutput("job1_idle", K_IDLE, 0);
      step();
      checkOutput("job1_idle2", K_IDLE, 0);

      // Consumer stalls five cycles on row 3.
      start = 1'b1;
      step();
      start = 1'b0;
      applyStimulus("stall", 3, 5);
      checkOutput("stall_idle", K_IDLE, 0);

      // Start held high: one job per IDLE visit, next job begins right after IDLE.
      start = 1'b1;
      step();
      applyStimulus("held1", -1, 0);
      checkOutput("held_idle", K_IDLE, 0);
      step();
      start = 1'b0;
      applyStimulus("held2", -1, 0);
      checkOutput("held2_idle", K_IDLE, 0);
      step();
      checkOutput("held2_idle2", K_IDLE, 0);

      // Reset at COMPUTE phase 10, with start also asserted during reset.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < CLR; k++) begin
         checkOutput("rstjob_clear", K_CLEAR, k);
         step();
      end
      for (int k = 0; k < 10; k++) begin
         checkOutput("rstjob_compute", K_COMP, k);
         step();
      end
      checkOutput("rstjob_compute", K_COMP, 10);
      rst = 1'b1;
      step();
      checkOutput("midreset", K_IDLE, 0);
      start = 1'b1;
      step();
      rst = 1'b0;
      start = 1'b0;
      checkOutput("start_in_reset", K_IDLE, 0);
      step();
      checkOutput("post_reset_idle", K_IDLE, 0);

      start = 1'b1;
      step();
      start = 1'b0;
      applyStimulus("after_rst", -1, 0);
      checkOutput("after_rst_idle", K_IDLE, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
